// File: rtl/verdict_pkg.sv
// Shared types and helpers for the verdict serializer.
// VERDICT_TIMESTAMP_EN adds the per-frame capture timestamp field.
package verdict_pkg;

  localparam int unsigned NUM_STREAMS_DEF = 3;
  localparam int unsigned DATA_WIDTH_DEF  = 64;
  localparam int unsigned TS_WIDTH_DEF    = 64;
  localparam int unsigned DEPTH_DEF       = 8;
  localparam int unsigned ID_WIDTH_DEF    = (NUM_STREAMS_DEF > 1) ? $clog2(NUM_STREAMS_DEF) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  typedef struct packed {
`ifdef VERDICT_TIMESTAMP_EN
    logic [TS_WIDTH_DEF-1:0]                   ts;
`endif
    logic [NUM_STREAMS_DEF-1:0]                mask;
    logic [NUM_STREAMS_DEF*DATA_WIDTH_DEF-1:0] values;
  } frame_t;

  // Index of the lowest set bit; 0 for an empty mask.
  function automatic logic [ID_WIDTH_DEF-1:0] lowest_set(input logic [NUM_STREAMS_DEF-1:0] m);
    logic [ID_WIDTH_DEF-1:0] idx;
    idx = '0;
    for (int i = NUM_STREAMS_DEF - 1; i >= 0; i--) begin
      if (m[i]) idx = ID_WIDTH_DEF'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/verdict_fifo.sv
// Synchronous frame FIFO; push and pop on the same edge are legal even when full.
module verdict_fifo
  import verdict_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  frame_t           wdata_i,
  output frame_t           rdata_c,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  frame_t           mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
    else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_c = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/verdict_serializer.sv
// Captures active monitor cycles as frames and replays them one stream per beat.
// VERDICT_TIMESTAMP_EN enables the cycle timestamp counter and v_time; otherwise v_time is 0.
module verdict_serializer
  import verdict_pkg::*;
#(
  parameter  int unsigned NUM_STREAMS = NUM_STREAMS_DEF,
  parameter  int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter  int unsigned TS_WIDTH    = TS_WIDTH_DEF,
  parameter  int unsigned DEPTH       = DEPTH_DEF,
  localparam int unsigned ID_W        = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [NUM_STREAMS*DATA_WIDTH-1:0] out_values,
  input  logic [NUM_STREAMS-1:0]            out_aktv,
  output logic                              v_valid,
  input  logic                              v_ready,
  output logic [ID_W-1:0]                   v_id,
  output logic [DATA_WIDTH-1:0]             v_value,
  output logic [TS_WIDTH-1:0]               v_time,
  output logic                              v_last,
  output logic                              overflow,
  output logic [15:0]                       drop_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  ser_state_t             state_q, state_d;
  frame_t                 hold_q, hold_d, wr_frame, rd_frame;
  logic [NUM_STREAMS-1:0] rem_rest;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full, fifo_empty;
  logic                   pop, push_req, push_ok, drop, last_beat;

  logic                   v_valid_q, v_valid_d;
  logic [ID_W-1:0]        v_id_q, v_id_d;
  logic [DATA_WIDTH-1:0]  v_value_q, v_value_d;
  logic                   v_last_q, v_last_d;
  logic                   overflow_q;
  logic [15:0]            drop_q;

`ifdef VERDICT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0]    ts_q, v_time_q, v_time_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ts_q <= '0;
    else if (en) ts_q <= ts_q + TS_WIDTH'(1);
  end
`endif

  // Capture side: a frame is lost only when the FIFO is full and nothing leaves this edge.
  assign push_req = en && (|out_aktv);
  assign push_ok  = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  always_comb begin
    wr_frame        = '0;
`ifdef VERDICT_TIMESTAMP_EN
    wr_frame.ts     = ts_q;
`endif
    wr_frame.mask   = out_aktv;
    wr_frame.values = out_values;
  end

  verdict_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_ok),
    .pop_i  (pop),
    .wdata_i(wr_frame),
    .rdata_c(rd_frame),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // hold_q.mask doubles as the set of streams still to be sent.
  assign rem_rest  = hold_q.mask & (hold_q.mask - NUM_STREAMS'(1));
  assign last_beat = (rem_rest == '0);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pop       = 1'b0;
    v_valid_d = 1'b0;
    v_id_d    = '0;
    v_value_d = '0;
    v_last_d  = 1'b0;
`ifdef VERDICT_TIMESTAMP_EN
    v_time_d  = '0;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          hold_d  = rd_frame;
          state_d = SEND;
        end
      end
      SEND: begin
        if (v_valid_q && v_ready) begin
          hold_d.mask = rem_rest;
          if (last_beat) begin
            if (!fifo_empty) begin
              pop    = 1'b1;
              hold_d = rd_frame;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Beat fields are registered from the next hold state so they stay put while stalled.
    if (state_d == SEND) begin
      v_valid_d = 1'b1;
      v_id_d    = lowest_set(hold_d.mask);
      for (int k = 0; k < NUM_STREAMS; k++) begin
        if (v_id_d == ID_W'(k)) v_value_d = hold_d.values[k*DATA_WIDTH +: DATA_WIDTH];
      end
      v_last_d  = ((hold_d.mask & (hold_d.mask - NUM_STREAMS'(1))) == '0);
`ifdef VERDICT_TIMESTAMP_EN
      v_time_d  = hold_d.ts;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      v_valid_q  <= 1'b0;
      v_id_q     <= '0;
      v_value_q  <= '0;
      v_last_q   <= 1'b0;
`ifdef VERDICT_TIMESTAMP_EN
      v_time_q   <= '0;
`endif
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      v_valid_q  <= v_valid_d;
      v_id_q     <= v_id_d;
      v_value_q  <= v_value_d;
      v_last_q   <= v_last_d;
`ifdef VERDICT_TIMESTAMP_EN
      v_time_q   <= v_time_d;
`endif
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (fifo_full == (fifo_count == CNT_W'(DEPTH)));
  end

  assign v_valid    = v_valid_q;
  assign v_id       = v_id_q;
  assign v_value    = v_value_q;
  assign v_last     = v_last_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
`ifdef VERDICT_TIMESTAMP_EN
  assign v_time     = v_time_q;
`else
  assign v_time     = '0;
`endif

endmodule

// File: tb/tb_verdict_serializer.sv
// Scoreboard bench for verdict_serializer: frame-level reference model plus beat monitor.
module tb_verdict_serializer;

  localparam int DEPTH = 8;
`ifdef VERDICT_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  typedef struct {
    logic [1:0]  id;
    logic [63:0] value;
    logic [63:0] ts;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [191:0] out_values = '0;
  logic [2:0]   out_aktv = '0;
  logic         v_ready = 1'b0;
  logic         v_valid;
  logic [1:0]   v_id;
  logic [63:0]  v_value;
  logic [63:0]  v_time;
  logic         v_last;
  logic         overflow;
  logic [15:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  verdict_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .out_values(out_values),
    .out_aktv  (out_aktv),
    .v_valid   (v_valid),
    .v_ready   (v_ready),
    .v_id      (v_id),
    .v_value   (v_value),
    .v_time    (v_time),
    .v_last    (v_last),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame queue of beat counts, one frame in service, expected beats in order.
  beat_t       exp_q[$];
  int          m_fq[$];
  bit          m_holding = 1'b0;
  int          m_rem = 0;
  bit          m_ovf = 1'b0;
  logic [15:0] m_drop = '0;
  logic [63:0] m_ts = '0;
  bit          m_hs, m_lastb, m_pop, m_push, m_acc;
  beat_t       m_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_fq.delete();
      m_holding = 1'b0;
      m_rem     = 0;
      m_ovf     = 1'b0;
      m_drop    = '0;
      m_ts      = '0;
    end else begin
      m_hs    = m_holding && v_ready;
      m_lastb = m_hs && (m_rem == 1);
      m_pop   = (!m_holding || m_lastb) && (m_fq.size() > 0);
      m_push  = en && (out_aktv != 3'd0);
      m_acc   = m_push && ((m_fq.size() < DEPTH) || m_pop);
      if (m_hs) m_rem--;
      if (m_pop) begin
        m_rem     = m_fq.pop_front();
        m_holding = 1'b1;
      end else if (m_lastb) begin
        m_holding = 1'b0;
      end
      if (m_acc) begin
        for (int k = 0; k < 3; k++) begin
          if (out_aktv[k]) begin
            m_b.id    = 2'(k);
            m_b.value = out_values[k*64 +: 64];
            m_b.ts    = TS_ON ? m_ts : 64'd0;
            m_b.last  = ((out_aktv >> (k + 1)) == 3'd0);
            exp_q.push_back(m_b);
          end
        end
        m_fq.push_back($countones(out_aktv));
      end else if (m_push) begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      if (en) m_ts = m_ts + 64'd1;
    end
  end

  // Monitor: compares every presented beat with the scoreboard head, pops on handshake.
  bit          prev_stall = 1'b0;
  logic [1:0]  prev_id;
  logic [63:0] prev_value, prev_time;
  logic        prev_last;
  beat_t       mb;

  always @(negedge clk) begin
    #1;
    chk("v_valid", 64'(v_valid), 64'(m_holding));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    if (!rst && prev_stall && v_valid) begin
      chk("stall_id", 64'(v_id), 64'(prev_id));
      chk("stall_value", v_value, prev_value);
      chk("stall_time", v_time, prev_time);
      chk("stall_last", 64'(v_last), 64'(prev_last));
    end
    if (!rst && v_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL beat_unexpected: got id %0d value 0x%0h, expected no beat", v_id, v_value);
      end else begin
        mb = exp_q[0];
        chk("beat_id", 64'(v_id), 64'(mb.id));
        chk("beat_value", v_value, mb.value);
        chk("beat_time", v_time, mb.ts);
        chk("beat_last", 64'(v_last), 64'(mb.last));
        if (v_ready) void'(exp_q.pop_front());
      end
    end
    prev_stall = !rst && v_valid && !v_ready;
    prev_id    = v_id;
    prev_value = v_value;
    prev_time  = v_time;
    prev_last  = v_last;
  end

  task automatic set_vals(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    out_values = {c, b, a};
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_v_valid"}, 64'(v_valid), 64'd0);
    chk({tag, "_v_id"}, 64'(v_id), 64'd0);
    chk({tag, "_v_value"}, v_value, 64'd0);
    chk({tag, "_v_time"}, v_time, 64'd0);
    chk({tag, "_v_last"}, 64'(v_last), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    chk({tag, "_drop_count"}, 64'(drop_count), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; out_aktv = '0; v_ready = 1'b0;
    #2 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || m_holding || m_fq.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("drain_pending_beats", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] t_exp;
    t_exp = TS_ON ? 64'd10 : 64'd0;

    // Reset values, then one full frame sampled at ts = 10.
    @(negedge clk);
    #2 check_reset_outputs("init");
    @(negedge clk);
    rst = 1'b0; en = 1'b1; v_ready = 1'b1;
    repeat (10) @(negedge clk);
    out_aktv = 3'b111; set_vals(64'd1, 64'd2, 64'd3);
    @(negedge clk);
    out_aktv = 3'b000;
    #2 chk("latency_one_cycle", 64'(v_valid), 64'd0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      #2;
      chk("f1_valid", 64'(v_valid), 64'd1);
      chk("f1_id", 64'(v_id), 64'(b));
      chk("f1_value", v_value, 64'(b + 1));
      chk("f1_time", v_time, t_exp);
      chk("f1_last", 64'(v_last), (b == 2) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    #2 chk("f1_idle_after", 64'(v_valid), 64'd0);

    // Sparse mask with a 5-cycle stall on the first beat.
    @(negedge clk);
    v_ready = 1'b0; out_aktv = 3'b101; set_vals(64'd7, 64'hDEAD, 64'd9);
    @(negedge clk);
    out_aktv = 3'b000;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      #2;
      chk("stall_hold_id", 64'(v_id), 64'd0);
      chk("stall_hold_value", v_value, 64'd7);
      chk("stall_hold_last", 64'(v_last), 64'd0);
    end
    @(negedge clk);
    v_ready = 1'b1;
    @(negedge clk);
    #2;
    chk("f2_id", 64'(v_id), 64'd2);
    chk("f2_value", v_value, 64'd9);
    chk("f2_last", 64'(v_last), 64'd1);
    drain(50);

    // Overflow: one frame stalled in service, then 10 active cycles into an empty FIFO.
    do_reset();
    en = 1'b1;
    out_aktv = 3'b001; set_vals({$urandom, $urandom}, 64'd0, 64'd0);
    @(negedge clk);
    out_aktv = 3'b000;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      out_aktv = 3'($urandom_range(1, 7));
      set_vals({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    end
    @(negedge clk);
    out_aktv = 3'b000;
    #2;
    chk("burst_drop_count", 64'(drop_count), 64'd2);
    chk("burst_overflow", 64'(overflow), 64'd1);

    // Full FIFO with the last beat leaving on the same edge as a new sample.
    @(negedge clk);
    v_ready = 1'b1; out_aktv = 3'b110;
    set_vals(64'd0, {$urandom, $urandom}, {$urandom, $urandom});
    @(negedge clk);
    out_aktv = 3'b000;
    #2 chk("full_pop_push_drop_count", 64'(drop_count), 64'd2);
    drain(200);

    // Enable low: no captures and a frozen timestamp, while a buffered frame still drains.
    v_ready = 1'b0; out_aktv = 3'b010; set_vals(64'd0, 64'h55, 64'd0);
    @(negedge clk);
    en = 1'b0; v_ready = 1'b1;
    repeat (4) @(negedge clk);
    en = 1'b1; out_aktv = 3'b100; set_vals(64'd0, 64'd0, 64'h66);
    @(negedge clk);
    out_aktv = 3'b000;
    drain(50);

    // Reset between beat 1 and beat 2 of a three-beat frame.
    out_aktv = 3'b111; set_vals(64'd11, 64'd22, 64'd33);
    @(negedge clk);
    out_aktv = 3'b000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #2 check_reset_outputs("midframe_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      en       = ($urandom_range(0, 3) != 0);
      out_aktv = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      v_ready  = ($urandom_range(0, 3) != 0);
      set_vals({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    end
    @(negedge clk);
    out_aktv = 3'b000; v_ready = 1'b1;
    drain(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
